fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Streaming-to-frame input stage for the 16-point FFT core. It accepts one complex Q16.16 sample per cycle over a valid/ready stream and assembles 16 consecutive samples into a frame. It presents each completed frame as the packed real and imaginary buses the combinational FFT core consumes, with a valid/ready handshake. Double buffering lets the next frame fill while the current one is held for the core and its consumer.

## Interface
- `N`, 16, samples per frame (FFT size)
- `W`, 32, bits per real/imag word (Q16.16 two's complement)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  loader can accept a sample this cycle
- `s_re`  in  W  real part of input sample
- `s_im`  in  W  imaginary part of input sample
- `s_last`  in  1  marks the final sample of a frame (index N-1)
- `m_valid`  out  1  packed frame valid
- `m_ready`  in  1  downstream accepts frame
- `m_re`  out  N*W  packed real frame; sample 0 in bits [N*W-1 -: W], sample N-1 in bits [W-1:0]
- `m_im`  out  N*W  packed imaginary frame, same ordering
- `frame_err`  out  1  one-cycle pulse on a framing mismatch

## Operation
- Storage: fill buffer (N×2×W), output register (N×2×W), sample index `cnt` (log2 N bits), state.
- A sample is accepted on a rising edge with `s_valid && s_ready`.
- States:
  - FILL: `s_ready`=1. An accepted sample is written to fill slot `cnt`.
    - At `cnt`<N-1 without `s_last`: `cnt`++.
    - At `cnt`=N-1 with `s_last`: `cnt`←0 and the state goes to FULL.
  - FULL: `s_ready`=0. Transfer happens when `!m_valid || m_ready`: the output register takes the fill buffer, `m_valid`←1, and the state goes to FILL.
  - RESYNC: `s_ready`=1. Accepted samples are dropped. An accepted sample with `s_last` sets `cnt`←0 and the state goes to FILL.
- Framing errors (each pulses `frame_err` for one cycle, discards the partial frame, and never disturbs the output register):
  - `s_last` accepted at `cnt`<N-1: `cnt`←0 and the state stays FILL.
  - Sample accepted at `cnt`=N-1 without `s_last`: the state goes to RESYNC.
- Output handshake:
  - If `m_valid && m_ready` and no transfer occurs on the same edge, `m_valid`←0.
  - A transfer and a drain on the same edge leave `m_valid`=1 with the new frame, so frames can be back-to-back.
- `m_re`/`m_im` change only on a transfer edge. They are stable while `m_valid && !m_ready`.
- No arithmetic is performed; samples pass bit-exact.

## Timing
- Reset values (asynchronous, immediate):
  - state=FILL, `cnt`=0
  - `m_valid`=0, `m_re`=0, `m_im`=0
  - `frame_err`=0
  - `s_ready`=1 (decoded from state)
- Latency: last sample accepted at edge k → `m_valid`=1 after edge k+1, provided the output register is free or draining at edge k+1.
- Throughput: at most N samples per N+1 cycles. `s_ready` is low for exactly one cycle per frame when the output is free.
- Backpressure: while the output is held (`m_valid && !m_ready`) and the fill buffer is complete, the loader stays in FULL with `s_ready`=0 indefinitely.
- `frame_err` is registered and high in the cycle after the offending acceptance.
- Reset mid-frame or mid-hold discards both buffers. `m_valid` drops asynchronously. The first post-reset accepted sample is index 0.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_N`=16 and `SAMPLE_W`=32
  - Q16.16 format constants (`Q_FRAC`=16)
  - the loader state enum {FILL, FULL, RESYNC}
  - the packing-order helper constant (sample i at bit offset (N-1-i)*W)
- One natural sub-module, `frame_reg`: an N-slot, 2W-wide register bank with an indexed write port and a packed parallel read.
  - It is instantiated twice: as the fill buffer and as the output register, the latter loaded in parallel.
- The control FSM, `cnt` and the handshake logic live in `fft_frame_loader`.

## Test plan
- Single frame, `m_ready`=1: stream re = {32'h0011_0000, 32'h1000_0000, 0×14}, im all 0, `s_last` on sample 15 → `m_valid` one cycle after the last acceptance; `m_re[511:480]`=32'h0011_0000, `m_re[479:448]`=32'h1000_0000, all other bits 0.
- Back-to-back frames with `s_valid` held high and `m_ready`=1: samples re=i+1 (i = 0..31) → two frames, `s_ready` low exactly one cycle per frame, frame 2 `m_re[W-1:0]`=32.
- Backpressure: `m_ready`=0 after frame 1 while 16 more samples are streamed → `s_ready`=0 after the 16th; `m_re` unchanged. Raising `m_ready` for one cycle delivers frame 2 on the next edge.
- Early `s_last` on sample 5 → `frame_err` pulse, no `m_valid`. The next 16 samples form a clean frame starting at index 0.
- Missing `s_last` at sample 15 → `frame_err` pulse and RESYNC. Three dropped samples, the third carrying `s_last`, are followed by a clean frame.
- Assert `rst` while `cnt`=9 and `m_valid`=1 → `m_valid`, `m_re` and `m_im` go to 0 immediately. After release, `s_ready`=1 and the next accepted sample lands at index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, loader state encoding and the frame packing-order helper
// for the 16-point FFT input stage.
package fft_pkg;

  localparam int FFT_N    = 16;
  localparam int SAMPLE_W = 32;
  localparam int Q_FRAC   = 16;
  localparam int CNT_W    = $clog2(FFT_N);
  localparam int FRAME_W  = FFT_N * SAMPLE_W;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FULL   = 2'd1,
    RESYNC = 2'd2
  } loader_state_t;

  // Bit offset of sample idx inside a packed frame: sample 0 sits in the
  // most significant word, sample n-1 in the least significant word.
  function automatic int slot_lsb(input int idx, input int n, input int w);
    return (n - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/frame_reg.sv
// N-slot register bank of complex samples: one indexed write port, one
// parallel load port and a packed parallel read in FFT frame order.
module frame_reg
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [W-1:0]         wr_re,
  input  logic [W-1:0]         wr_im,
  input  logic                 ld_en,
  input  logic [N*W-1:0]       ld_re,
  input  logic [N*W-1:0]       ld_im,
  output logic [N*W-1:0]       rd_re,
  output logic [N*W-1:0]       rd_im
);

  logic [W-1:0] re_mem [N];
  logic [W-1:0] im_mem [N];

  // Slot storage: parallel load has priority over the single indexed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        re_mem[i] <= {W{1'b0}};
        im_mem[i] <= {W{1'b0}};
      end
    end else if (ld_en) begin
      for (int i = 0; i < N; i++) begin
        re_mem[i] <= ld_re[slot_lsb(i, N, W) +: W];
        im_mem[i] <= ld_im[slot_lsb(i, N, W) +: W];
      end
    end else if (wr_en) begin
      re_mem[wr_idx] <= wr_re;
      im_mem[wr_idx] <= wr_im;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign rd_re[slot_lsb(g, N, W) +: W] = re_mem[g];
    assign rd_im[slot_lsb(g, N, W) +: W] = im_mem[g];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Streaming-to-frame loader: collects N complex samples from a valid/ready
// stream into a fill buffer, then hands the completed frame to a held output
// register. Framing errors discard the partial frame and pulse frame_err.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_re,
  input  logic [W-1:0] s_im,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N*W-1:0] m_re,
  output logic [N*W-1:0] m_im,
  output logic         frame_err
);

  localparam int CNT_W_L = $clog2(N);
  localparam logic [CNT_W_L-1:0] LAST_IDX = CNT_W_L'(N - 1);
  localparam logic [CNT_W_L-1:0] CNT_ONE  = CNT_W_L'(1);

  loader_state_t         state;
  logic [CNT_W_L-1:0]    cnt;
  logic                  accept;
  logic                  transfer;
  logic                  fill_wr;
  logic [N*W-1:0]        fill_re;
  logic [N*W-1:0]        fill_im;

  assign s_ready  = (state != FULL);
  assign accept   = s_valid && s_ready;
  // A completed frame moves out when the output register is empty or draining.
  assign transfer = (state == FULL) && (!m_valid || m_ready);
  assign fill_wr  = accept && (state == FILL);

  frame_reg #(.N(N), .W(W)) fill_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fill_wr),
    .wr_idx (cnt),
    .wr_re  (s_re),
    .wr_im  (s_im),
    .ld_en  (1'b0),
    .ld_re  ({(N*W){1'b0}}),
    .ld_im  ({(N*W){1'b0}}),
    .rd_re  (fill_re),
    .rd_im  (fill_im)
  );

  frame_reg #(.N(N), .W(W)) out_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (1'b0),
    .wr_idx ({CNT_W_L{1'b0}}),
    .wr_re  ({W{1'b0}}),
    .wr_im  ({W{1'b0}}),
    .ld_en  (transfer),
    .ld_re  (fill_re),
    .ld_im  (fill_im),
    .rd_re  (m_re),
    .rd_im  (m_im)
  );

  // Loader FSM: sample index, framing checks and output-valid handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= {CNT_W_L{1'b0}};
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      case (state)
        FILL: begin
          if (accept) begin
            if (s_last) begin
              cnt <= {CNT_W_L{1'b0}};
              if (cnt == LAST_IDX) begin
                state <= FULL;
              end else begin
                // Early end of frame: drop the partial frame, restart at 0.
                frame_err <= 1'b1;
              end
            end else if (cnt == LAST_IDX) begin
              // Frame overran without a marker: hunt for the next s_last.
              cnt       <= {CNT_W_L{1'b0}};
              frame_err <= 1'b1;
              state     <= RESYNC;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        FULL: begin
          if (transfer) begin
            state <= FILL;
          end
        end
        RESYNC: begin
          if (accept && s_last) begin
            cnt   <= {CNT_W_L{1'b0}};
            state <= FILL;
          end
        end
        default: begin
          state <= FILL;
          cnt   <= {CNT_W_L{1'b0}};
        end
      endcase

      // A transfer wins over a drain so frames can go out back-to-back.
      if (transfer) begin
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_re;
  logic [W-1:0]  s_im;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_re;
  logic [FW-1:0] m_im;
  logic          frame_err;

  fft_frame_loader #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_re      (m_re),
    .m_im      (m_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int low_cnt     = 0;

  // Behavioural model: partial frame as queues, one pending complete frame,
  // and the frame currently presented downstream.
  logic [W-1:0]  part_re[$];
  logic [W-1:0]  part_im[$];
  logic          resync;
  logic          have_pend;
  logic [FW-1:0] pend_re, pend_im;
  logic          out_valid;
  logic [FW-1:0] out_re, out_im;
  logic          exp_err;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    part_re.delete();
    part_im.delete();
    resync    = 1'b0;
    have_pend = 1'b0;
    pend_re   = '0;
    pend_im   = '0;
    out_valid = 1'b0;
    out_re    = '0;
    out_im    = '0;
    exp_err   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                            input logic last, input logic mr);
    logic acc, xfer;
    acc     = v && !have_pend;
    xfer    = have_pend && (!out_valid || mr);
    exp_err = 1'b0;
    if (xfer) begin
      out_re    = pend_re;
      out_im    = pend_im;
      out_valid = 1'b1;
      have_pend = 1'b0;
    end else if (out_valid && mr) begin
      out_valid = 1'b0;
    end
    if (acc) begin
      if (resync) begin
        if (last) resync = 1'b0;
      end else begin
        part_re.push_back(re);
        part_im.push_back(im);
        if (last) begin
          if (part_re.size() == N) begin
            for (int i = 0; i < N; i++) begin
              pend_re[(N-1-i)*W +: W] = part_re[i];
              pend_im[(N-1-i)*W +: W] = part_im[i];
            end
            have_pend = 1'b1;
          end else begin
            exp_err = 1'b1;
          end
          part_re.delete();
          part_im.delete();
        end else if (part_re.size() == N) begin
          exp_err = 1'b1;
          resync  = 1'b1;
          part_re.delete();
          part_im.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    check("s_ready", s_ready, !have_pend);
    check("m_valid", m_valid, out_valid);
    check("frame_err", frame_err, exp_err);
    check("m_re", m_re, out_re);
    check("m_im", m_im, out_im);
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                     input logic last, input logic mr);
    s_valid = v;
    s_re    = re;
    s_im    = im;
    s_last  = last;
    m_ready = mr;
    @(posedge clk);
    model_step(v, re, im, last, mr);
    @(negedge clk);
    compare_all();
    if (!s_ready) low_cnt++;
  endtask

  // Present one sample until it is accepted (bounded).
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last,
                      input logic mr);
    int n;
    n = 0;
    while (have_pend && n < 64) begin
      cyc(1'b1, re, im, last, mr);
      n++;
    end
    if (have_pend) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: sample %h not accepted within 64 cycles", re);
    end else begin
      cyc(1'b1, re, im, last, mr);
    end
  endtask

  logic [W-1:0] word;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_re", m_re, '0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;

    // Single frame with two non-zero leading samples.
    for (int i = 0; i < N; i++) begin
      word = (i == 0) ? 32'h0011_0000 : (i == 1) ? 32'h1000_0000 : 32'h0;
      send(word, 32'h0, i == N - 1, 1'b1);
    end
    check("t1_not_yet_valid", m_valid, 1'b0);
    check("t1_full_not_ready", s_ready, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t1_valid", m_valid, 1'b1);
    check("t1_m_re", m_re, {32'h0011_0000, 32'h1000_0000, 448'h0});
    check("t1_m_im", m_im, '0);

    // Back-to-back frames with m_ready held high.
    low_cnt = 0;
    for (int i = 0; i < 2 * N; i++) send(32'(i + 1), ~32'(i + 1), (i % N) == N - 1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("t2_ready_low_cycles", 32'(low_cnt), 32'd2);
    word = m_re[W-1:0];
    check("t2_last_word", word, 32'd32);
    check("t2_valid", m_valid, 1'b1);

    // Backpressure: frame 2 held while frame 3 fills.
    for (int i = 0; i < N; i++) send(32'(100 + i), 32'(i), i == N - 1, 1'b0);
    check("t3_stall", s_ready, 1'b0);
    word = m_re[W-1:0];
    check("t3_held_word", word, 32'd32);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("t3_still_stalled", s_ready, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    word = m_re[W-1:0];
    check("t3_new_word", word, 32'd115);
    check("t3_valid", m_valid, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("t3_drained", m_valid, 1'b0);

    // Early s_last on sample 5.
    for (int i = 0; i < 6; i++) send(32'(200 + i), 32'h0, i == 5, 1'b1);
    check("t4_err", frame_err, 1'b1);
    check("t4_no_valid", m_valid, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("t4_err_pulse", frame_err, 1'b0);
    for (int i = 0; i < N; i++) send(32'(300 + i), 32'h0, i == N - 1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    word = m_re[FW-1 -: W];
    check("t4_first_word", word, 32'd300);

    // Missing s_last, resync on the third dropped sample.
    for (int i = 0; i < N; i++) send(32'(400 + i), 32'h0, 1'b0, 1'b0);
    check("t5_err", frame_err, 1'b1);
    check("t5_resync_ready", s_ready, 1'b1);
    for (int i = 0; i < 3; i++) send(32'(500 + i), 32'h0, i == 2, 1'b0);
    for (int i = 0; i < N; i++) send(32'(600 + i), 32'(i), i == N - 1, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    word = m_re[FW-1 -: W];
    check("t5_first_word", word, 32'd600);
    word = m_re[W-1:0];
    check("t5_last_word", word, 32'd615);

    // Reset mid-frame while the output is held.
    for (int i = 0; i < 9; i++) send(32'(700 + i), 32'h0, 1'b0, 1'b0);
    check("t6_pre_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_m_re", m_re, '0);
    check("t6_rst_m_im", m_im, '0);
    check("t6_rst_ready", s_ready, 1'b1);
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) send(32'(800 + i), 32'h0, i == N - 1, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    word = m_re[FW-1 -: W];
    check("t6_first_word", word, 32'd800);

    // Random traffic with mostly well-formed framing.
    for (int c = 0; c < 3000; c++) begin
      logic v, mr, last;
      v  = $urandom_range(0, 9) < 7;
      mr = $urandom_range(0, 9) < 6;
      if (resync)                        last = $urandom_range(0, 3) == 0;
      else if (part_re.size() == N - 1)  last = $urandom_range(0, 15) != 0;
      else                               last = $urandom_range(0, 19) == 0;
      cyc(v, $urandom, $urandom, last, mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
